// File: rtl/simple_restoring_div.sv
// Unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional `DIV_ZERO_CHECK_EN: zero divisor bypasses CALC and flags div_zero.
module simple_restoring_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] prem_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] prem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             last_step;

    assign last_step = (cnt_q == CW'(WIDTH - 1));

    // Borrow out of the (WIDTH+1)-bit trial subtraction decides the quotient bit;
    // the stored remainder always fits WIDTH bits since it stays below the divisor.
    always_comb begin
        trial    = {prem_q, dvd_q[WIDTH-1]};
        diff     = trial - {1'b0, dsr_q};
        q_bit    = ~diff[WIDTH];
        prem_nxt = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nxt  = {dvd_q[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef DIV_ZERO_CHECK_EN
                    state_nxt = (divisor == '0) ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q     <= '0;
            dsr_q     <= '0;
            prem_q    <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q  <= dividend;
                        dsr_q  <= divisor;
                        prem_q <= '0;
                        cnt_q  <= '0;
`ifdef DIV_ZERO_CHECK_EN
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
`endif
                    end
                end
                CALC: begin
                    dvd_q  <= quo_nxt;
                    prem_q <= prem_nxt;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_step) begin
                        quotient  <= quo_nxt;
                        remainder <= prem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            div_zero <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            if (divisor == '0) begin
                div_zero <= 1'b1;
            end
        end else if (state == CALC && last_step) begin
            div_zero <= 1'b0;
        end
    end
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: doc/simple_restoring_div.md
SIMPLE_RESTORING_DIV -- requirements
Module: simple_restoring_div

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand and result width in bits (legal range 2..64).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand pair valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: dividend  input  WIDTH  unsigned dividend.
REQ-007 SHALL have port: divisor  input  WIDTH  unsigned divisor.
REQ-008 SHALL have port: out_valid  output  1  result valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: quotient  output  WIDTH  unsigned quotient.
REQ-011 SHALL have port: remainder  output  WIDTH  unsigned remainder.
REQ-012 SHALL have port: div_zero  output  1  result came from a zero divisor.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC, DONE.
REQ-014 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-015 SHALL accept operands on a rising edge where in_valid && in_ready, latching dividend and divisor, clearing the partial remainder (WIDTH+1 bits) and the step counter.
REQ-016 SHALL, on acceptance with nonzero divisor, enter CALC.
REQ-017 SHALL, in CALC, perform one restoring step per cycle: shift next dividend MSB into the partial remainder; if partial remainder >= divisor, subtract and shift in quotient bit 1, else shift in 0.
REQ-018 SHALL remain in CALC exactly WIDTH cycles, entering DONE on the edge completing step WIDTH; out_valid SHALL be high after the WIDTH-th edge following the accept edge.
REQ-019 SHALL, in DONE, hold quotient, remainder and div_zero stable while out_ready is low.
REQ-020 SHALL, in DONE with out_ready high, return to IDLE on that edge; in_ready SHALL rise the following cycle (no same-cycle reissue).
REQ-021 SHALL ignore in_valid outside IDLE and out_ready outside DONE.
REQ-022 SHALL satisfy dividend == quotient*divisor + remainder, remainder < divisor, for every nonzero divisor.
REQ-023 SHALL produce quotient = all ones and remainder = dividend for divisor == 0.
REQ-024 SHALL never change quotient/remainder/div_zero except on entry to DONE or reset.

Reset
REQ-025 SHALL, on rst high at a rising edge, enter IDLE regardless of state (including mid-CALC and DONE), discarding any operation in progress.
REQ-026 SHALL reset outputs: in_ready 1 after the reset edge, out_valid 0, quotient 0, remainder 0, div_zero 0.
REQ-027 SHALL give rst priority over in_valid on the same edge (no acceptance).

Configuration
REQ-028 SHALL use macro DIV_ZERO_CHECK_EN.
REQ-029 SHALL, with DIV_ZERO_CHECK_EN defined, go directly from IDLE to DONE on accepting divisor == 0, presenting the REQ-023 result with div_zero = 1 and out_valid high after the accept edge (latency 1).
REQ-030 SHALL, without DIV_ZERO_CHECK_EN, process divisor == 0 through CALC like any other operand (latency WIDTH, same REQ-023 result arising naturally) with div_zero tied to 0.

Verification (WIDTH=8)
REQ-031 SHALL cover: 200/7, out_ready held high -> quotient 28, remainder 4, div_zero 0, out_valid 8 edges after accept.
REQ-032 SHALL cover: 255/1 then 5/9 back-to-back -> (255,0) then (0,5); second acceptance no earlier than 1 cycle after first DONE exit.
REQ-033 SHALL cover: 77/0 -> quotient 255, remainder 77; with DIV_ZERO_CHECK_EN div_zero 1, latency 1; without, div_zero 0, latency 8.
REQ-034 SHALL cover: 100/3 with out_ready low 20 cycles after out_valid -> (33,1) held stable all 20 cycles, IDLE one edge after out_ready rises.
REQ-035 SHALL cover: rst asserted on 4th CALC cycle of 250/3 -> IDLE, out_valid never rises, outputs 0; next 250/3 -> (83,1).
REQ-036 SHALL cover: random 10,000 operand pairs incl. 0 and 255 -> REQ-022 holds, in_ready/out_valid never both high.
